// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback requesters.
// Optional macro REGFILE_WB_BYPASS_EN adds a combinational read bypass of the in-flight write.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [ADDR_W-1:0]          wb_addr,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       wb_enable,
    output logic [ID_W-1:0]            grant_id
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]          rd_addr_a,
    input  logic [ADDR_W-1:0]          rd_addr_b,
    input  logic [DATA_W-1:0]          rf_data_a,
    input  logic [DATA_W-1:0]          rf_data_b,
    output logic [DATA_W-1:0]          byp_data_a,
    output logic [DATA_W-1:0]          byp_data_b
`endif
);

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_c;
    logic [ID_W-1:0]   nxt_ptr_c;
    logic              found_c;
    logic              hs_c;
    int unsigned       idx_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping to 0.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found_c && req_valid[ID_W'(idx_c)]) begin
                found_c = 1'b1;
                win_c   = ID_W'(idx_c);
            end
        end
    end

    assign hs_c      = found_c & ~stall & rst_n;
    assign req_ready = hs_c ? (NUM_REQ'(1) << win_c) : '0;
    assign nxt_ptr_c = (win_c == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win_c + 1'b1);

    // Writes to r0 complete the handshake but never enable the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr   <= '0;
            wb_data   <= '0;
            wb_enable <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else if (hs_c) begin
            wb_addr   <= addr_arr[win_c];
            wb_data   <= data_arr[win_c];
            wb_enable <= (addr_arr[win_c] != '0);
            grant_id  <= win_c;
            rr_ptr    <= nxt_ptr_c;
        end else begin
            wb_enable <= 1'b0;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // wb_enable already excludes r0, so a match implies a nonzero read address.
    assign byp_data_a = (wb_enable && (wb_addr == rd_addr_a)) ? wb_data : rf_data_a;
    assign byp_data_b = (wb_enable && (wb_addr == rd_addr_b)) ? wb_data : rf_data_b;
`endif

endmodule
